wt_mem_req_arbiter: RTL
=======================

Name: wt_mem_req_arbiter

Overview:
- Shares the single memory request channel of the write-through cache subsystem between the I$ (source 0) and the D$ (source 1).
- Round-robin arbitration with a one-entry registered output stage.
- Per-source outstanding-transaction limit.
- Routes return-valid pulses back to the originating cache.
- Sits between wt_icache/wt_dcache and the memory adapter (AXI or L1.5).

Parameters:
- PayloadWidth, 128, width of the opaque request payload (address, size, tid, data) forwarded unchanged.
- MaxOutstanding, 4, maximum requests in flight per source; legal range 1..15.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- ic_req_i  in  1  I$ request valid; held until ic_ack_o
- ic_data_i  in  PayloadWidth  I$ payload; stable while ic_req_i high
- ic_ack_o  out  1  single-cycle accept pulse to I$
- dc_req_i  in  1  D$ request valid; held until dc_ack_o
- dc_data_i  in  PayloadWidth  D$ payload
- dc_ack_o  out  1  single-cycle accept pulse to D$
- mem_req_o  out  1  registered request valid to adapter
- mem_data_o  out  PayloadWidth  registered payload
- mem_src_o  out  1  source of current request (0 = I$, 1 = D$)
- mem_gnt_i  in  1  adapter accepts mem_req_o this cycle
- rtrn_vld_i  in  1  memory return valid
- rtrn_src_i  in  1  source tag of return
- ic_rtrn_vld_o  out  1  = rtrn_vld_i & ~rtrn_src_i (combinational)
- dc_rtrn_vld_o  out  1  = rtrn_vld_i & rtrn_src_i (combinational)
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst_i high at clock edge; overrides all other events):
  - FSM to IDLE, mem_req_o=0, mem_data_o=0, mem_src_o=0.
  - ic_ack_o=0, dc_ack_o=0, err_o=0, both counters 0, RR pointer = 0 (I$ favoured).
  - Reset mid-HOLD discards the latched request; no grant is owed.
- Eligibility: source s is eligible when req_s & (cnt_s < MaxOutstanding).
- FSM IDLE:
  - No eligible source: stay IDLE, no ack.
  - One eligible source: select it.
  - Both eligible: select the source indicated by the RR pointer.
  - On selection in cycle N:
    - ack_s=1 in cycle N (combinational from registered state + inputs).
    - Payload and source latched; mem_req_o=1 from cycle N+1.
    - cnt_s increments at the end of cycle N.
    - RR pointer set to ~s.
    - Next state HOLD.
- FSM HOLD:
  - mem_req_o=1; mem_data_o and mem_src_o stable; no acks.
  - On mem_gnt_i: next state IDLE, mem_req_o=0 next cycle.
  - Minimum spacing between accepted requests: 2 cycles (one bubble).
- Counters: 4-bit, per source.
  - Decrement on the routed return pulse for that source.
  - Acceptance and return for the same source in the same cycle: counter unchanged.
  - Return with cnt_s==0: counter stays 0 (no wrap), err_o set.
  - Increment never exceeds MaxOutstanding, because eligibility gates it.
- err_o also sets if mem_gnt_i arrives while IDLE. Cleared only by reset.
- Return routing is zero-latency and independent of FSM state.

Optional Feature:
- Macro WT_ARB_ICACHE_PRIO_EN.
- Defined: fixed priority; I$ wins whenever both sources are eligible. RR pointer not implemented.
- Undefined: round-robin as above.
- Counter limits and error behaviour are identical in both builds.

Test Plan:
- Reset, then ic_req_i=1 only with ic_data_i=0xA5 -> ic_ack_o pulse in cycle 1; mem_req_o=1, mem_src_o=0, mem_data_o=0xA5 from cycle 2; mem_gnt_i in cycle 4 -> mem_req_o=0 in cycle 5; I$ count=1.
- ic_req_i and dc_req_i held high continuously, mem_gnt_i tied 1, returns each cycle for the previous source -> grants alternate I$, D$, I$, D$. With WT_ARB_ICACHE_PRIO_EN: I$ only, until its count reaches 4.
- dc_req_i held, no returns, MaxOutstanding=4 -> exactly 4 dc_ack_o pulses, then stall. One D$ return -> exactly one further ack.
- Same-cycle D$ acceptance and D$ return at count 3 -> count stays 3.
- rtrn_vld_i=1, rtrn_src_i=0 with I$ count 0 -> ic_rtrn_vld_o=1, count stays 0, err_o=1 and stays high until rst_i.
- rst_i asserted in HOLD with mem_req_o=1 -> next cycle mem_req_o=0, counts 0, err_o=0; a following request is accepted normally.

Source files
------------

// File: rtl/wt_mem_req_arbiter.sv
// rtl/wt_mem_req_arbiter.sv - I$/D$ memory request arbiter with outstanding limits
//
// Shares the single memory request channel between the I$ (source 0) and the
// D$ (source 1). A one-entry registered output stage holds the winning request
// until the adapter grants it. Each source may have at most MaxOutstanding
// requests in flight; returns are routed back by their source tag.
//
// Optional build macro: WT_ARB_ICACHE_PRIO_EN
//   defined   - fixed priority, I$ wins when both sources are eligible
//   undefined - round-robin between the two sources
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   ic_req_i/ic_data_i/ic_ack_o  I$ request, payload, accept pulse
//   dc_req_i/dc_data_i/dc_ack_o  D$ request, payload, accept pulse
//   mem_req_o/mem_data_o/mem_src_o/mem_gnt_i  registered request to adapter
//   rtrn_vld_i/rtrn_src_i        memory return valid and source tag
//   ic_rtrn_vld_o/dc_rtrn_vld_o  routed return pulses
//   err_o                        sticky protocol error (underflow, stray grant)

module wt_mem_req_arbiter #(
    parameter int PayloadWidth   = 128,
    parameter int MaxOutstanding = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ic_req_i,
    input  logic [PayloadWidth-1:0] ic_data_i,
    output logic                    ic_ack_o,
    input  logic                    dc_req_i,
    input  logic [PayloadWidth-1:0] dc_data_i,
    output logic                    dc_ack_o,
    output logic                    mem_req_o,
    output logic [PayloadWidth-1:0] mem_data_o,
    output logic                    mem_src_o,
    input  logic                    mem_gnt_i,
    input  logic                    rtrn_vld_i,
    input  logic                    rtrn_src_i,
    output logic                    ic_rtrn_vld_o,
    output logic                    dc_rtrn_vld_o,
    output logic                    err_o
);

    localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [PayloadWidth-1:0] mem_data_q;
    logic                    mem_src_q;
    logic [3:0]              ic_cnt_q, dc_cnt_q;
    logic                    err_q;

    logic ic_elig, dc_elig;
    logic both_pick;
    logic accept;
    logic sel_src;
    logic ic_ret, dc_ret;
    logic ic_inc, dc_inc;

    // Return routing is purely combinational and ignores the FSM.
    assign ic_ret        = rtrn_vld_i & ~rtrn_src_i;
    assign dc_ret        = rtrn_vld_i &  rtrn_src_i;
    assign ic_rtrn_vld_o = ic_ret;
    assign dc_rtrn_vld_o = dc_ret;

    assign ic_elig = ic_req_i & (ic_cnt_q < MaxCnt);
    assign dc_elig = dc_req_i & (dc_cnt_q < MaxCnt);

`ifdef WT_ARB_ICACHE_PRIO_EN
    assign both_pick = 1'b0;
`else
    // Round-robin pointer: names the source favoured on the next tie.
    logic rr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b0;
        end else if (accept) begin
            rr_q <= ~sel_src;
        end
    end

    assign both_pick = rr_q;
`endif

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        sel_src  = 1'b0;
        ic_ack_o = 1'b0;
        dc_ack_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ic_elig && dc_elig) begin
                    sel_src = both_pick;
                end else begin
                    sel_src = dc_elig;
                end
                // Acks are suppressed during reset so nothing is accepted
                // that the reset would then discard.
                accept   = (ic_elig | dc_elig) & ~rst_i;
                ic_ack_o = accept & ~sel_src;
                dc_ack_o = accept &  sel_src;
                if (accept) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (mem_gnt_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ic_inc = ic_ack_o;
    assign dc_inc = dc_ack_o;

    // Simultaneous accept and return cancel; a return at zero saturates.
    function automatic logic [3:0] cnt_next(logic [3:0] cnt, logic inc, logic dec);
        logic [3:0] res;
        res = cnt;
        case ({inc, dec})
            2'b10:   res = cnt + 4'd1;
            2'b01:   res = (cnt == 4'd0) ? cnt : cnt - 4'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mem_data_q <= '0;
            mem_src_q  <= 1'b0;
            ic_cnt_q   <= 4'd0;
            dc_cnt_q   <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mem_data_q <= sel_src ? dc_data_i : ic_data_i;
                mem_src_q  <= sel_src;
            end
            ic_cnt_q <= cnt_next(ic_cnt_q, ic_inc, ic_ret);
            dc_cnt_q <= cnt_next(dc_cnt_q, dc_inc, dc_ret);
            if ((ic_ret && ic_cnt_q == 4'd0) ||
                (dc_ret && dc_cnt_q == 4'd0) ||
                (state_q == IDLE && mem_gnt_i)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_req_o  = (state_q == HOLD);
    assign mem_data_o = mem_data_q;
    assign mem_src_o  = mem_src_q;
    assign err_o      = err_q;

endmodule
